// File: rtl/apb_cmd_pkg.sv
// apb_cmd_pkg: shared encodings for the APB command master.
// State codes and response status bit positions.
package apb_cmd_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_t;

  localparam int STS_ERR     = 0;
  localparam int STS_TIMEOUT = 1;
  localparam int STS_W       = 2;

  function automatic logic [STS_W-1:0] sts(
    input logic err,
    input logic tmo
  );
    sts = '0;
    sts[STS_ERR]     = err;
    sts[STS_TIMEOUT] = tmo;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: request/response stream plus APB3 bus.
// master = command master view, slave = requester and APB slave view.
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 2,
  parameter int SEL_WIDTH  = 1
);

  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WRITE;
  logic [SEL_WIDTH-1:0]  REQ_SLV;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  RSP_TIMEOUT;
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_SLV,
    input  REQ_ADDR, REQ_WDATA, RSP_READY,
    input  PRDATA, PREADY, PSLVERR,
    output REQ_READY, RSP_VALID, RSP_RDATA,
    output RSP_ERR, RSP_TIMEOUT,
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_SLV,
    output REQ_ADDR, REQ_WDATA, RSP_READY,
    output PRDATA, PREADY, PSLVERR,
    input  REQ_READY, RSP_VALID, RSP_RDATA,
    input  RSP_ERR, RSP_TIMEOUT,
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA
  );

endinterface

// File: rtl/apb_cmd_timer.sv
// apb_cmd_timer: saturating ACCESS wait counter.
// expired is high on the last allowed wait cycle; LIMIT 0 never expires.
module apb_cmd_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TOP =
    (LIMIT > 0) ? CW'(LIMIT - 1) : {CW{1'b1}};

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && count != TOP) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT > 0) ? (count == TOP) : 1'b0;

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready request stream to APB3 SETUP/ACCESS cycles.
// Handles PREADY timeout and out-of-range slave decode errors.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 2,
  parameter int SEL_WIDTH  = 1,
  parameter int TIMEOUT    = 16
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_cmd_master_if.master bus
);

  state_t state_q, state_d;

  logic                  write_q;
  logic [SEL_WIDTH-1:0]  slv_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [STS_W-1:0]      sts_q;

  logic accept, dec_err;
  logic cap_ok, cap_to, cap_dec;
  logic tmr_clr, tmr_en, tmr_exp;

  assign dec_err = int'(bus.REQ_SLV) >= NUM_SLAVES;

  apb_cmd_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cap_ok  = 1'b0;
    cap_to  = 1'b0;
    cap_dec = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.REQ_VALID) begin
          accept  = 1'b1;
          cap_dec = dec_err;
          state_d = dec_err ? RESP : SETUP;
        end
      end
      SETUP: begin
        tmr_clr = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over an expiring timer
        if (bus.PREADY) begin
          cap_ok  = 1'b1;
          state_d = RESP;
        end else if (tmr_exp) begin
          cap_to  = 1'b1;
          state_d = RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RESP: begin
        if (bus.RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      write_q <= 1'b0;
      slv_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sts_q   <= '0;
    end else begin
      if (accept) begin
        write_q <= bus.REQ_WRITE;
        slv_q   <= bus.REQ_SLV;
        addr_q  <= bus.REQ_ADDR;
        wdata_q <= bus.REQ_WDATA;
      end
      unique case (1'b1)
        cap_ok: begin
          rdata_q <= write_q ? '0 : bus.PRDATA;
          sts_q   <= sts(bus.PSLVERR, 1'b0);
        end
        cap_to, cap_dec: begin
          rdata_q <= '0;
          sts_q   <= sts(1'b1, cap_to);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.PSEL = '0;
    if (state_q == SETUP || state_q == ACCESS) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        bus.PSEL[i] = (slv_q == SEL_WIDTH'(i));
      end
    end
  end

  assign bus.REQ_READY   = (state_q == IDLE);
  assign bus.PENABLE     = (state_q == ACCESS);
  assign bus.RSP_VALID   = (state_q == RESP);
  assign bus.PWRITE      = write_q;
  assign bus.PADDR       = addr_q;
  assign bus.PWDATA      = wdata_q;
  assign bus.RSP_RDATA   = rdata_q;
  assign bus.RSP_ERR     = sts_q[STS_ERR];
  assign bus.RSP_TIMEOUT = sts_q[STS_TIMEOUT];

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized bench with a transaction-level model.
// Includes a per-cycle APB protocol monitor.
module tb_apb_cmd_master;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NS = 2;
  localparam int SW = 2;
  localparam int TO = 16;

  logic PCLK = 1'b0;
  logic PRESET;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_cmd_master_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_SLAVES(NS), .SEL_WIDTH(SW)
  ) bus ();

  apb_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_SLAVES(NS), .SEL_WIDTH(SW),
    .TIMEOUT(TO)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  typedef struct {
    int lat; int setup; int acc;
    logic [NS-1:0] psel;
    logic err; logic tmo;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    int lat; int setup; int acc; int unstable; int hold_same;
    logic [NS-1:0] psel;
    logic [AW-1:0] paddr;
    logic pwrite;
    logic [DW-1:0] pwdata;
    logic rdy_req; logic rv; logic err; logic tmo; logic rdy_rsp;
    logic [DW-1:0] rdata;
    logic rv_after; logic rdy_after;
    logic [NS-1:0] psel_after;
  } obs_t;

  // Transaction outcome from the block's rules, not its cycle logic
  function automatic exp_t model(
    input logic wr, input int slv, input int waits,
    input logic slverr, input logic [DW-1:0] prdata
  );
    exp_t e;
    e.lat = 1; e.setup = 0; e.acc = 0; e.psel = '0;
    e.err = 1'b1; e.tmo = 1'b0; e.rdata = '0;
    if (slv < NS) begin
      e.setup = 1;
      e.acc   = (waits < TO) ? waits + 1 : TO;
      e.lat   = 2 + e.acc;
      e.psel  = NS'(1) << slv;
      e.tmo   = (waits >= TO);
      e.err   = e.tmo | slverr;
      e.rdata = (e.tmo || wr) ? '0 : prdata;
    end
    return e;
  endfunction

  task automatic run_xfer(
    input logic wr, input int slv,
    input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
    input int waits, input logic slverr,
    input logic [DW-1:0] prdata, input int hold,
    output obs_t o
  );
    logic [AW+DW:0] cmd0, cmd;
    logic [DW+NS+4:0] snap;
    bit seen;
    o = '{default: 0};
    seen = 0;
    cmd0 = '0;
    bus.REQ_WRITE = wr;
    bus.REQ_SLV   = SW'(slv);
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wdata;
    bus.REQ_VALID = 1'b1;
    o.rdy_req = bus.REQ_READY;
    @(posedge PCLK); #1;
    bus.REQ_VALID = 1'b0;
    o.lat = 1;
    while (!bus.RSP_VALID && o.lat < 40) begin
      if (bus.PSEL != '0) begin
        o.psel |= bus.PSEL;
        cmd = {bus.PWRITE, bus.PADDR, bus.PWDATA};
        if (!seen) begin
          seen = 1; cmd0 = cmd;
          o.pwrite = bus.PWRITE;
          o.paddr  = bus.PADDR;
          o.pwdata = bus.PWDATA;
        end else if (cmd != cmd0) begin
          o.unstable++;
        end
        if (bus.PENABLE) o.acc++;
        else o.setup++;
      end
      if (bus.PENABLE && o.acc > waits) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = slverr;
        bus.PRDATA  = prdata;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = DW'($urandom);
      end
      @(posedge PCLK); #1;
      o.lat++;
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    o.rv      = bus.RSP_VALID;
    o.err     = bus.RSP_ERR;
    o.tmo     = bus.RSP_TIMEOUT;
    o.rdata   = bus.RSP_RDATA;
    o.rdy_rsp = bus.REQ_READY;
    snap = {bus.RSP_VALID, bus.RSP_ERR,
            bus.RSP_TIMEOUT, bus.RSP_RDATA,
            bus.REQ_READY, bus.PSEL, bus.PENABLE};
    for (int h = 0; h < hold; h++) begin
      bus.REQ_VALID = 1'b1;
      bus.REQ_SLV   = SW'($urandom_range(0, 1));
      bus.REQ_ADDR  = AW'($urandom);
      bus.REQ_WRITE = 1'($urandom_range(0, 1));
      bus.RSP_READY = 1'b0;
      @(posedge PCLK); #1;
      if ({bus.RSP_VALID, bus.RSP_ERR,
           bus.RSP_TIMEOUT, bus.RSP_RDATA,
           bus.REQ_READY, bus.PSEL,
           bus.PENABLE} == snap)
        o.hold_same++;
    end
    bus.REQ_VALID = 1'b0;
    bus.RSP_READY = 1'b1;
    @(posedge PCLK); #1;
    bus.RSP_READY = 1'b0;
    o.rv_after   = bus.RSP_VALID;
    o.rdy_after  = bus.REQ_READY;
    o.psel_after = bus.PSEL;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    tests++;
    if ({bus.PSEL, bus.PENABLE, bus.RSP_VALID, bus.RSP_ERR,
         bus.RSP_TIMEOUT, bus.PWRITE} !== '0) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 0",
        {bus.PSEL, bus.PENABLE, bus.RSP_VALID,
         bus.RSP_ERR, bus.RSP_TIMEOUT, bus.PWRITE});
    end
    tests++;
    if ({bus.PADDR, bus.PWDATA, bus.RSP_RDATA} !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0",
        {bus.PADDR, bus.PWDATA, bus.RSP_RDATA});
    end
    tests++;
    if (bus.REQ_READY !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", bus.REQ_READY);
    end
    PRESET = 1'b0;
  endtask

  task automatic test_write_basic();
    exp_t e; obs_t o;
    e = model(1'b1, 0, 0, 1'b0, 8'h77);
    run_xfer(1'b1, 0, 5'h00, 8'hA5, 0, 1'b0, 8'h77, 0, o);
    tests++;
    if (o.rdy_req !== 1'b1) begin
      fails++; $display("FAIL wr_ready: got %b want 1", o.rdy_req);
    end
    tests++;
    if (o.psel !== e.psel) begin
      fails++; $display("FAIL wr_psel: got %b want %b", o.psel, e.psel);
    end
    tests++;
    if (o.setup !== e.setup || o.acc !== e.acc) begin
      fails++;
      $display("FAIL wr_phases: got %0d/%0d want %0d/%0d",
        o.setup, o.acc, e.setup, e.acc);
    end
    tests++;
    if ({o.pwrite, o.pwdata} !== {1'b1, 8'hA5}) begin
      fails++;
      $display("FAIL wr_cmd: got %b/%h want 1/a5", o.pwrite, o.pwdata);
    end
    tests++;
    if (o.lat !== e.lat) begin
      fails++; $display("FAIL wr_lat: got %0d want %0d", o.lat, e.lat);
    end
    tests++;
    if ({o.rv, o.err, o.tmo, o.rdata} !== {1'b1, e.err, e.tmo, e.rdata}) begin
      fails++;
      $display("FAIL wr_rsp: got %b%b%b/%h want 1%b%b/%h",
        o.rv, o.err, o.tmo, o.rdata, e.err, e.tmo, e.rdata);
    end
    tests++;
    if ({o.rv_after, o.rdy_after} !== 2'b01) begin
      fails++;
      $display("FAIL wr_release: got %b%b want 01", o.rv_after, o.rdy_after);
    end
  endtask

  task automatic test_read_waits();
    exp_t e; obs_t o;
    e = model(1'b0, 1, 3, 1'b0, 8'h3C);
    run_xfer(1'b0, 1, 5'h04, DW'($urandom), 3, 1'b0, 8'h3C, 0, o);
    tests++;
    if (o.acc !== e.acc || o.lat !== e.lat) begin
      fails++;
      $display("FAIL rd_access: got %0d/%0d want %0d/%0d",
        o.acc, o.lat, e.acc, e.lat);
    end
    tests++;
    if ({o.psel, o.paddr} !== {e.psel, 5'h04} || o.unstable !== 0) begin
      fails++;
      $display("FAIL rd_cmd: got %b/%h/%0d want %b/04/0",
        o.psel, o.paddr, o.unstable, e.psel);
    end
    tests++;
    if ({o.err, o.tmo, o.rdata} !== {e.err, e.tmo, e.rdata}) begin
      fails++;
      $display("FAIL rd_rsp: got %b%b/%h want %b%b/%h",
        o.err, o.tmo, o.rdata, e.err, e.tmo, e.rdata);
    end
  endtask

  task automatic test_timeout();
    exp_t e; obs_t o;
    int wt[3] = '{15, 16, 30};
    for (int k = 0; k < 3; k++) begin
      e = model(1'b0, 0, wt[k], 1'b0, 8'hC3);
      run_xfer(1'b0, 0, 5'h1F, 8'h00, wt[k], 1'b0, 8'hC3, 0, o);
      tests++;
      if (o.acc !== e.acc || o.lat !== e.lat) begin
        fails++;
        $display("FAIL to_access w%0d: got %0d/%0d want %0d/%0d",
          wt[k], o.acc, o.lat, e.acc, e.lat);
      end
      tests++;
      if ({o.err, o.tmo, o.rdata} !== {e.err, e.tmo, e.rdata}) begin
        fails++;
        $display("FAIL to_rsp w%0d: got %b%b/%h want %b%b/%h",
          wt[k], o.err, o.tmo, o.rdata, e.err, e.tmo, e.rdata);
      end
    end
  endtask

  task automatic test_errors();
    exp_t e; obs_t o;
    e = model(1'b1, 1, 2, 1'b1, 8'h55);
    run_xfer(1'b1, 1, 5'h08, 8'h12, 2, 1'b1, 8'h55, 0, o);
    tests++;
    if ({o.err, o.tmo, o.rdata} !== {e.err, e.tmo, e.rdata}) begin
      fails++;
      $display("FAIL slverr_rsp: got %b%b/%h want %b%b/%h",
        o.err, o.tmo, o.rdata, e.err, e.tmo, e.rdata);
    end
    for (int s = 2; s < 4; s++) begin
      e = model(1'b0, s, 0, 1'b0, 8'h99);
      run_xfer(1'b0, s, 5'h03, 8'h44, 0, 1'b0, 8'h99, 0, o);
      tests++;
      if (o.lat !== e.lat || o.psel !== e.psel || o.setup !== e.setup) begin
        fails++;
        $display("FAIL decode s%0d: got lat%0d psel%b want lat%0d psel%b",
          s, o.lat, o.psel, e.lat, e.psel);
      end
      tests++;
      if ({o.rv, o.err, o.tmo, o.rdata} !== {1'b1, e.err, e.tmo, e.rdata}) begin
        fails++;
        $display("FAIL decode_rsp s%0d: got %b%b%b/%h want 1%b%b/%h",
          s, o.rv, o.err, o.tmo, o.rdata, e.err, e.tmo, e.rdata);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; obs_t o;
    e = model(1'b0, 1, 1, 1'b0, 8'h6B);
    run_xfer(1'b0, 1, 5'h0A, 8'h00, 1, 1'b0, 8'h6B, 5, o);
    tests++;
    if (o.hold_same !== 5 || o.rdy_rsp !== 1'b0) begin
      fails++;
      $display("FAIL bp_hold: got %0d/%b want 5/0", o.hold_same, o.rdy_rsp);
    end
    tests++;
    if (o.rdata !== e.rdata) begin
      fails++; $display("FAIL bp_rdata: got %h want %h", o.rdata, e.rdata);
    end
    tests++;
    if ({o.rv_after, o.rdy_after, o.psel_after} !== {2'b01, 2'b00}) begin
      fails++;
      $display("FAIL bp_release: got %b%b/%b want 01/00",
        o.rv_after, o.rdy_after, o.psel_after);
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e; obs_t o;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_SLV   = 2'd0;
    bus.REQ_ADDR  = 5'h11;
    bus.REQ_VALID = 1'b1;
    @(posedge PCLK); #1;
    bus.REQ_VALID = 1'b0;
    @(posedge PCLK); #1;
    tests++;
    if (bus.PENABLE !== 1'b1) begin
      fails++; $display("FAIL mid_pre: got %b want 1", bus.PENABLE);
    end
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    tests++;
    if ({bus.PSEL, bus.PENABLE, bus.RSP_VALID, bus.REQ_READY} !== 5'b00001)
    begin
      fails++;
      $display("FAIL mid_rst: got %b want 00001",
        {bus.PSEL, bus.PENABLE, bus.RSP_VALID, bus.REQ_READY});
    end
    @(posedge PCLK); #1;
    tests++;
    if ({bus.PSEL, bus.RSP_VALID, bus.REQ_READY} !== 4'b0001) begin
      fails++;
      $display("FAIL mid_discard: got %b want 0001",
        {bus.PSEL, bus.RSP_VALID, bus.REQ_READY});
    end
    e = model(1'b0, 1, 2, 1'b0, 8'hE7);
    run_xfer(1'b0, 1, 5'h06, 8'h00, 2, 1'b0, 8'hE7, 0, o);
    tests++;
    if (o.lat !== e.lat || {o.err, o.rdata} !== {e.err, e.rdata}) begin
      fails++;
      $display("FAIL mid_after: got %0d %b/%h want %0d %b/%h",
        o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o;
    int c0, s;
    logic wr;
    logic [DW-1:0] d;
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      s  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      d  = DW'($urandom);
      e = model(wr, s, 0, 1'b0, d);
      run_xfer(wr, s, AW'($urandom), DW'($urandom), 0, 1'b0, d, 0, o);
      tests++;
      if ({o.err, o.rdata} !== {e.err, e.rdata}) begin
        fails++;
        $display("FAIL b2b_rsp %0d: got %b/%h want %b/%h",
          k, o.err, o.rdata, e.err, e.rdata);
      end
    end
    tests++;
    if (cyc - c0 !== 24) begin
      fails++; $display("FAIL b2b_rate: got %0d want 24", cyc - c0);
    end
  endtask

  task automatic test_random();
    exp_t e; obs_t o;
    int wt[8] = '{0, 1, 2, 3, 5, 14, 15, 16};
    int s, w, hd;
    logic wr, se;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, pd;
    for (int k = 0; k < 25; k++) begin
      s  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3))
                                       : int'($urandom_range(0, 1));
      w  = wt[$urandom_range(0, 7)];
      wr = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 3) == 0);
      a  = AW'($urandom);
      wd = DW'($urandom);
      pd = DW'($urandom);
      hd = int'($urandom_range(0, 2));
      e = model(wr, s, w, se, pd);
      run_xfer(wr, s, a, wd, w, se, pd, hd, o);
      tests++;
      if (o.lat !== e.lat || o.acc !== e.acc || o.psel !== e.psel) begin
        fails++;
        $display("FAIL rnd_timing %0d: got %0d/%0d/%b want %0d/%0d/%b",
          k, o.lat, o.acc, o.psel, e.lat, e.acc, e.psel);
      end
      tests++;
      if ({o.rv, o.err, o.tmo, o.rdata} !== {1'b1, e.err, e.tmo, e.rdata}) begin
        fails++;
        $display("FAIL rnd_rsp %0d: got %b%b%b/%h want 1%b%b/%h",
          k, o.rv, o.err, o.tmo, o.rdata, e.err, e.tmo, e.rdata);
      end
      tests++;
      if (o.hold_same !== hd || {o.rv_after, o.rdy_after} !== 2'b01) begin
        fails++;
        $display("FAIL rnd_hold %0d: got %0d %b%b want %0d 01",
          k, o.hold_same, o.rv_after, o.rdy_after, hd);
      end
      if (e.setup == 1) begin
        tests++;
        if ({o.pwrite, o.paddr, o.pwdata} !== {wr, a, wd} ||
            o.unstable !== 0) begin
          fails++;
          $display("FAIL rnd_cmd %0d: got %b/%h/%h/%0d want %b/%h/%h/0",
            k, o.pwrite, o.paddr, o.pwdata, o.unstable, wr, a, wd);
        end
      end
    end
  endtask

  logic [NS-1:0]  pp = '0;
  logic           pe = 1'b0;
  logic           pr = 1'b1;
  logic [AW+DW:0] pc = '0;

  always @(negedge PCLK) begin
    tests++;
    if ((bus.PENABLE && bus.PSEL == '0) || !$onehot0(bus.PSEL)) begin
      fails++;
      $display("FAIL apb_sel: got psel %b en %b want onehot with en",
        bus.PSEL, bus.PENABLE);
    end
    if (!pr && pp != '0 && !pe &&
        !(bus.PENABLE && bus.PSEL == pp)) begin
      fails++;
      $display("FAIL apb_setup: got psel %b en %b want %b en 1",
        bus.PSEL, bus.PENABLE, pp);
    end
    if (!pr && pp != '0 && bus.PSEL == pp &&
        {bus.PWRITE, bus.PADDR, bus.PWDATA} != pc) begin
      fails++;
      $display("FAIL apb_stable: got %h want %h",
        {bus.PWRITE, bus.PADDR, bus.PWDATA}, pc);
    end
    pp = bus.PSEL;
    pe = bus.PENABLE;
    pr = PRESET;
    pc = {bus.PWRITE, bus.PADDR, bus.PWDATA};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET        = 1'b1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_SLV   = '0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WDATA = '0;
    bus.RSP_READY = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    test_reset();
    test_write_basic();
    test_read_waits();
    test_timeout();
    test_errors();
    test_backpressure();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
